muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: start  input  1  issue request from EX stage, sampled in IDLE only.
REQ-005 SHALL have port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: operand_a  input  WIDTH  rs1 value (forwarded).
REQ-007 SHALL have port: operand_b  input  WIDTH  rs2 value (forwarded).
REQ-008 SHALL have port: flush  input  1  abort in-flight operation (branch/PCSrc flush).
REQ-009 SHALL have port: busy_alu  output  1  unit occupied; consumed by hazard unit.
REQ-010 SHALL have port: valid_alu  output  1  result valid this cycle; consumed by hazard unit.
REQ-011 SHALL have port: result  output  WIDTH  RV32M result, held until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; busy_alu = (state != IDLE); valid_alu = (state == DONE).
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch funct3 and operands, clear iteration counter to 0, and go to CALC next cycle.
REQ-014 SHALL ignore start while in CALC or DONE (no re-latch, no restart).
REQ-015 SHALL, in CALC, perform one radix-2 iteration per cycle (shift-add for MUL*, restoring subtract-shift for DIV*/REM*) on operand magnitudes.
REQ-016 SHALL take magnitudes per op: MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU/MUL unsigned-treated (MUL low word sign-independent).
REQ-017 SHALL leave CALC for DONE after exactly WIDTH iterations (counter WIDTH-1 reached); latency start-edge to valid_alu = WIDTH+1 cycles.
REQ-018 SHALL, on CALC exit, sign-correct: product negated if operand signs differ (signed-op cases); quotient negated if signs differ; remainder takes dividend sign.
REQ-019 SHALL select result: MUL product[WIDTH-1:0]; MULH/MULHSU/MULHU product[2*WIDTH-1:WIDTH]; DIV*/REM* quotient/remainder.
REQ-020 SHALL, for divide-by-zero, skip CALC (IDLE->DONE, latency 1): DIV/DIVU all ones, REM/REMU operand_a.
REQ-021 SHALL, for signed overflow (DIV/REM, a = -2^(WIDTH-1), b = -1), skip CALC: DIV result a, REM result 0.
REQ-022 SHALL hold DONE exactly one cycle (busy_alu=1, valid_alu=1, releasing the stall), then return to IDLE.
REQ-023 SHALL, with flush=1 in any state, go to IDLE next cycle with valid_alu never asserted for the aborted op; result unchanged.
REQ-024 SHALL give flush priority over start in the same cycle (request dropped).
REQ-025 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back throughput WIDTH+2 cycles).
REQ-026 SHALL use 2*WIDTH-bit product accumulator and WIDTH+1-bit partial remainder; no overflow beyond these widths.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, counter 0, accumulators 0, result 0, busy_alu=0, valid_alu=0, asynchronously.
REQ-028 SHALL, on reset mid-CALC, discard the operation; no valid_alu after rst_n deasserts.

Verification
REQ-029 SHALL cover MUL: a=7, b=-3 (0xFFFFFFFD) -> busy 33 cycles, valid_alu one cycle at cycle 33, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-030 SHALL cover DIV/REM: a=-7, b=2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1); DIVU 100/7 -> 14, REMU -> 2.
REQ-031 SHALL cover special cases: DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 SHALL cover flush: start MUL, flush at CALC cycle 10 -> IDLE next cycle, valid_alu stays 0, result keeps prior value; start+flush same cycle -> stays IDLE.
REQ-033 SHALL cover start while busy: second start with different operands at cycle 5 -> ignored, first result delivered unchanged; back-to-back start in IDLE after DONE -> accepted.
REQ-034 SHALL cover async reset: rst_n low mid-CALC between clock edges -> busy_alu/valid_alu/result 0 immediately, IDLE after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy_alu,
  output logic             valid_alu,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_mag_r, b_mag_r, quo, quo_nx, rem, rem_nx, fin;
  logic [2*WIDTH-1:0] prod, prod_nx, prod_fin;
  logic [WIDTH:0] sum, shifted;
  logic neg_q, neg_r, ge;
  logic signed_a, signed_b, a_neg, b_neg, div_zero, ovf, special, accept, last;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;
  // Issue-time decode: operand signedness, magnitudes and the two shortcut cases
  always_comb begin
    signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    signed_b = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg = signed_a & operand_a[WIDTH-1];
    b_neg = signed_b & operand_b[WIDTH-1];
    a_mag = a_neg ? -operand_a : operand_a;
    b_mag = b_neg ? -operand_b : operand_b;
    div_zero = funct3[2] && operand_b == '0;
    ovf = funct3[2] && !funct3[0] && operand_a == {1'b1, {(WIDTH-1){1'b0}}} && &operand_b;
    special = div_zero | ovf;
    special_res = div_zero ? (funct3[1] ? operand_a : '1) : (funct3[1] ? '0 : operand_a);
    accept = state == IDLE && start && !flush;
    last = state == CALC && cnt == CW'(WIDTH-1);
  end
  // One shift-add and one restoring subtract-shift step, plus sign-corrected final result
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag_r} : '0);
    prod_nx = {sum, prod[WIDTH-1:1]};
    shifted = {rem, quo[WIDTH-1]};
    ge = shifted >= {1'b0, b_mag_r};
    rem_nx = WIDTH'(shifted - (ge ? {1'b0, b_mag_r} : '0));
    quo_nx = {quo[WIDTH-2:0], ge};
    prod_fin = neg_q ? -prod_nx : prod_nx;
    fin = op[2] ? (op[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx))
                : (op[1:0] == 2'b00 ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH]);
  end
  // State register; reset and flush both return to IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: flush wins, shortcut ops go straight to DONE, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = start ? (special ? DONE : CALC) : IDLE;
    else if (state == CALC) state_nx = last ? DONE : CALC;
    else state_nx = IDLE;
  end
  // Datapath: latch on accept, iterate in CALC, write result only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      cnt <= '0;
      a_mag_r <= '0;
      b_mag_r <= '0;
      prod <= '0;
      quo <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op <= funct3;
      cnt <= '0;
      a_mag_r <= a_mag;
      b_mag_r <= b_mag;
      prod <= {{WIDTH{1'b0}}, b_mag};
      quo <= a_mag;
      rem <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (special) result <= special_res;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 1'b1;
      prod <= prod_nx;
      quo <= quo_nx;
      rem <= rem_nx;
      if (last) result <= fin;
    end
  end
  assign busy_alu = state != IDLE;
  assign valid_alu = state == DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic busy_alu, valid_alu;
  logic [31:0] result;
  int vectors = 0, miscompares = 0;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy_alu(busy_alu), .valid_alu(valid_alu), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Issue one op at a negedge, wait (bounded) for valid, check result/latency/busy, then idle
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, nbusy;
    funct3 = f; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = int'(busy_alu);
    while (!valid_alu && lat < 100) begin
      @(negedge clk);
      lat++;
      nbusy += int'(busy_alu);
    end
    check({tag, "_valid"}, 64'(valid_alu), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(exp));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 64'(valid_alu), 64'd0);
    check({tag, "_idle_after"}, 64'(busy_alu), 64'd0);
  endtask
  initial begin
    int seen_valid, lat;
    #1;
    check("reset_busy", 64'(busy_alu), 64'd0);
    check("reset_valid", 64'(valid_alu), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy_alu), 64'd0);
    run("mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh", MULH, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run("mulhu", MULHU, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
    run("mulhsu_pos", MULHSU, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
    run("mulhsu_neg", MULHSU, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 33);
    run("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("divu", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu", REMU, 32'd100, 32'd7, 32'd2, 33);
    run("div_neg_a", DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
    run("rem_neg_a", REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
    run("div_neg_b", DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run("rem_neg_b", REM, 32'd100, 32'hFFFFFFF9, 32'd2, 33);
    run("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("rem_by0", REM, 32'd5, 32'd0, 32'd5, 1);
    // Flush at CALC cycle 10: abort, no valid, result stays 5
    funct3 = MUL; operand_a = 32'd7; operand_b = 32'hFFFFFFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_in_calc_busy", 64'(busy_alu), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'(busy_alu), 64'd0);
    check("flush_result_kept", 64'(result), 64'd5);
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      seen_valid += int'(valid_alu);
    end
    check("flush_no_valid", 64'(seen_valid), 64'd0);
    check("flush_result_still", 64'(result), 64'd5);
    // Start and flush together: request dropped
    funct3 = DIVU; operand_a = 32'd9; operand_b = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", 64'(busy_alu), 64'd0);
    @(negedge clk);
    check("start_flush_no_valid", 64'(valid_alu), 64'd0);
    check("start_flush_result", 64'(result), 64'd5);
    run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    // Second start while busy is ignored
    funct3 = DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    funct3 = MUL; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    while (!valid_alu && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_valid", 64'(valid_alu), 64'd1);
    check("busy_start_result", 64'(result), 64'd14);
    check("busy_start_latency", 64'(lat), 64'd33);
    @(negedge clk);
    check("busy_start_idle", 64'(busy_alu), 64'd0);
    // Async reset mid-CALC between edges
    funct3 = MUL; operand_a = 32'd7; operand_b = 32'hFFFFFFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_alu), 64'd0);
    check("arst_valid", 64'(valid_alu), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      seen_valid += int'(valid_alu) + int'(busy_alu);
    end
    check("arst_discarded", 64'(seen_valid), 64'd0);
    run("after_reset_remu", REMU, 32'd100, 32'd7, 32'd2, 33);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
